// File: rtl/adc_seq_ctrl_if.sv
// Sample stream interface between the ADC sequencer and the downstream
// sample buffer.
//   data        captured conversion word, MSB first from the ADC
//   data_valid  word available, held until accepted
//   data_ready  consumer accepts the word on this cycle
// master: sequencer side, slave: sample buffer side.
interface adc_seq_ctrl_if #(
  parameter int unsigned SAMPLE_BITS = 8
) ();
  logic [SAMPLE_BITS-1:0] data;
  logic                   data_valid;
  logic                   data_ready;

  modport master (
    output data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/adc_seq_ctrl.sv
// Sequencer for a serial, sleep-gated ADC front end.
// Drives the ADC reset/sleep controls, deserialises the 1-bit ADC stream into
// SAMPLE_BITS-wide words (MSB first) and offers them on a valid/ready stream.
// Supports single-shot and continuous conversion with a programmable sleep gap.
// Ports:
//   clk, rst_n    system clock (also the ADC clock), async active-low reset
//   start         start request, only looked at in IDLE
//   cont          continuous mode, sampled at each word completion
//   period        sleep cycles between words in continuous mode
//   adc_dout      ADC serial data
//   adc_rst       ADC reset (active high, registered)
//   adc_slp       ADC sleep / clock gate (1 = gated, registered)
//   overrun       sticky: an unaccepted word was overwritten
//   clr_overrun   clears overrun (a same-cycle set wins)
//   busy          controller is not idle
//   smp           sample stream (data / data_valid / data_ready)
module adc_seq_ctrl #(
  parameter int unsigned SAMPLE_BITS = 8,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned PERIOD_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cont,
  input  logic [PERIOD_W-1:0] period,
  input  logic                adc_dout,
  output logic                adc_rst,
  output logic                adc_slp,
  output logic                overrun,
  input  logic                clr_overrun,
  output logic                busy,
  adc_seq_ctrl_if.master      smp
);

  // One counter serves the reset hold, the bit count and the sleep gap.
  localparam int unsigned CntW = (PERIOD_W > 16) ? PERIOD_W : 16;

  typedef enum logic [1:0] {StIdle, StRst, StShift, StSleep} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
  logic [SAMPLE_BITS-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   adc_rst_q, adc_rst_d;
  logic                   adc_slp_q, adc_slp_d;
  logic [SAMPLE_BITS-1:0] shift_word;
  logic                   word_done;

  // Sample the pre-edge dout, i.e. the bit the ADC presents before it rotates.
  assign shift_word = {shreg_q[SAMPLE_BITS-2:0], adc_dout};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    adc_rst_d = adc_rst_q;
    adc_slp_d = adc_slp_q;
    word_done = 1'b0;

    if (valid_q && smp.data_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        adc_rst_d = 1'b0;
        adc_slp_d = 1'b1;
        if (start) begin
          state_d   = StRst;
          adc_rst_d = 1'b1;
          cnt_d     = '0;
        end
      end
      StRst: begin
        if (cnt_q == CntW'(RST_CYCLES - 1)) begin
          state_d   = StShift;
          adc_rst_d = 1'b0;
          adc_slp_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        shreg_d = shift_word;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(SAMPLE_BITS - 1)) begin
          word_done = 1'b1;
          cnt_d     = '0;
          if (cont && (period == '0)) begin
            // Gap-free stream: ADC clock keeps running into the next word.
            state_d = StShift;
          end else if (cont) begin
            adc_slp_d = 1'b1;
            cnt_d     = CntW'(period);
            state_d   = StSleep;
          end else begin
            adc_slp_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StSleep: begin
        if (cnt_q == CntW'(1)) begin
          adc_slp_d = 1'b0;
          cnt_d     = '0;
          state_d   = StShift;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (word_done) begin
      data_d  = shift_word;
      valid_d = 1'b1;
      // Completion on an acceptance cycle is a clean hand-over, not an overrun.
      if (valid_q && !smp.data_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      adc_rst_q <= 1'b1;
      adc_slp_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      adc_rst_q <= adc_rst_d;
      adc_slp_q <= adc_slp_d;
    end
  end

  assign adc_rst        = adc_rst_q;
  assign adc_slp        = adc_slp_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != StIdle);
  assign smp.data       = data_q;
  assign smp.data_valid = valid_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Self-checking bench for adc_seq_ctrl. A behavioural ADC (rotating shift
// register, reloaded while adc_rst is high, clocked only while adc_slp is low)
// feeds the DUT. Expected waveforms come from a timeline model: word n of a run
// has its ADC-clock window at cycles [R + n*(B+P), R + n*(B+P) + B - 1] after
// the start-sampling edge and completes on the following edge.
module tb_adc_seq_ctrl;
  localparam int SB = 8;
  localparam int RC = 2;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          cont;
  logic [PW-1:0] period;
  logic          adc_dout;
  logic          adc_rst;
  logic          adc_slp;
  logic          overrun;
  logic          clr_overrun;
  logic          busy;

  logic [SB-1:0] adc_word;
  logic [SB-1:0] adc_sr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference handshake state
  logic          m_valid;
  logic          m_ovr;
  logic [SB-1:0] m_data;

  adc_seq_ctrl_if #(.SAMPLE_BITS(SB)) smp ();

  adc_seq_ctrl #(
    .SAMPLE_BITS(SB),
    .RST_CYCLES (RC),
    .PERIOD_W   (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
    .period     (period),
    .adc_dout   (adc_dout),
    .adc_rst    (adc_rst),
    .adc_slp    (adc_slp),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .busy       (busy),
    .smp        (smp)
  );

  always #5 clk = ~clk;

  // ADC: outputs its MSB, rotates on each ungated edge, reloads while in reset.
  always @(posedge clk) begin
    if (adc_rst) begin
      adc_sr <= adc_word;
    end else if (!adc_slp) begin
      adc_sr <= {adc_sr[SB-2:0], adc_sr[SB-1]};
    end
  end
  assign adc_dout = adc_sr[SB-1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic e_rst, input logic e_slp, input logic e_busy);
    check_eq("adc_rst", 32'(adc_rst), 32'(e_rst));
    check_eq("adc_slp", 32'(adc_slp), 32'(e_slp));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("data_valid", 32'(smp.data_valid), 32'(m_valid));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("data", 32'(smp.data), 32'(m_data));
  endtask

  // One clock: apply inputs, advance the handshake model on the edge, check.
  task automatic step(input logic st, input logic ct, input logic rd, input logic cl,
                      input logic comp, input logic e_rst, input logic e_slp,
                      input logic e_busy);
    logic set_ovr;
    start          = st;
    cont           = ct;
    smp.data_ready = rd;
    clr_overrun    = cl;
    @(posedge clk);
    set_ovr = comp && m_valid && !rd;
    if (m_valid && rd) m_valid = 1'b0;
    if (comp) begin
      m_data  = adc_word;
      m_valid = 1'b1;
    end
    if (cl) m_ovr = 1'b0;
    if (set_ovr) m_ovr = 1'b1;
    @(negedge clk);
    check_outputs(e_rst, e_slp, e_busy);
  endtask

  task automatic idle_step(input logic rd, input logic cl);
    step(1'b0, 1'b0, rd, cl, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // rdmode: 0 random, 1 always ready, 2 never ready.
  // noise: random start while busy and random cont away from completion edges.
  task automatic run(input logic [SB-1:0] word, input int w, input int p, input int rdmode,
                     input bit clr_rand, input bit noise);
    int   per;
    int   c_last;
    int   n;
    logic st, ct, rd, cl, comp, low;
    adc_word = word;
    period   = PW'(p);
    per      = SB + p;
    c_last   = RC + SB + (w - 1) * per;
    for (int k = 0; k <= c_last + 3; k++) begin
      comp = 1'b0;
      n    = 0;
      if (k >= RC + SB && ((k - RC - SB) % per) == 0 && ((k - RC - SB) / per) < w) begin
        comp = 1'b1;
        n    = (k - RC - SB) / per;
      end
      low = (k >= RC) && (k < c_last) && (((k - RC) % per) < SB);
      if (k == 0)                    st = 1'b1;
      else if (noise && k <= c_last) st = 1'($urandom_range(0, 1));
      else                           st = 1'b0;
      if (comp)       ct = (n < w - 1);
      else if (noise) ct = 1'($urandom_range(0, 1));
      else            ct = (w > 1);
      if (rdmode == 0)      rd = 1'($urandom_range(0, 1));
      else if (rdmode == 1) rd = 1'b1;
      else                  rd = 1'b0;
      cl = clr_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      step(st, ct, rd, cl, comp, k < RC, !low, k < c_last);
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    start          = 1'b0;
    cont           = 1'b0;
    period         = '0;
    clr_overrun    = 1'b0;
    smp.data_ready = 1'b0;
    adc_word       = 8'h55;
    m_valid        = 1'b0;
    m_ovr          = 1'b0;
    m_data         = '0;

    #2 rst_n = 1'b0;
    #1 check_outputs(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_outputs(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    // adc_rst drops on the first edge out of reset, sleep stays on
    idle_step(1'b0, 1'b0);
    idle_step(1'b0, 1'b0);

    // Single-shot
    run(8'h55, 1, 0, 1, 1'b0, 1'b0);
    // Continuous with a 3-cycle sleep gap
    run(8'h55, 3, 3, 1, 1'b0, 1'b0);
    // Gap-free continuous
    run(8'h55, 3, 0, 1, 1'b0, 1'b0);

    // Backpressure: second word overwrites the first and flags overrun
    run(8'hA3, 2, 2, 2, 1'b0, 1'b0);
    check_eq("bp_valid_held", 32'(smp.data_valid), 32'd1);
    check_eq("bp_overrun_set", 32'(overrun), 32'd1);
    check_eq("bp_data", 32'(smp.data), 32'hA3);
    idle_step(1'b0, 1'b1);
    check_eq("bp_overrun_clr", 32'(overrun), 32'd0);
    idle_step(1'b1, 1'b0);
    check_eq("bp_valid_clr", 32'(smp.data_valid), 32'd0);

    // Abort mid-word at shift bit 4, then a clean conversion
    adc_word = 8'h3C;
    period   = '0;
    for (int k = 0; k <= RC + 4; k++) begin
      step(k == 0, 1'b1, 1'b1, 1'b0, 1'b0, k < RC, !(k >= RC), 1'b1);
    end
    rst_n   = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = '0;
    #1 check_outputs(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_step(1'b0, 1'b0);
    run(8'h55, 1, 0, 1, 1'b0, 1'b0);
    check_eq("abort_clean_word", 32'(smp.data), 32'h55);

    // Randomised runs: words, run length, gap, backpressure, clears, misuse
    for (int r = 0; r < 20; r++) begin
      run(SB'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 4)), 0,
          1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
- Sequencer for the serial sleep-gated ADC front end.
- Drives the ADC reset and sleep controls and deserialises the ADC's 1-bit data stream into SAMPLE_BITS-wide words, MSB first.
- Presents each word on a valid/ready interface to the downstream sample buffer.
- Supports single-shot and periodic continuous conversion, with a programmable sleep gap between words.

Parameters:
- SAMPLE_BITS, 8, bits per conversion word; ADC receives exactly this many gated clock edges per word.
- RST_CYCLES, 2, cycles adc_rst is held high before the first word of a start.
- PERIOD_W, 16, width of the period input.

Ports:
- clk  in  1  system clock; same clock feeds the ADC.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start request, level-sampled in IDLE.
- cont  in  1  continuous mode, sampled at each word completion.
- period  in  PERIOD_W  sleep cycles between words in continuous mode.
- adc_dout  in  1  ADC serial data.
- adc_rst  out  1  ADC reset, active high, registered.
- adc_slp  out  1  ADC sleep, 1 = ADC clock gated, registered.
- data  out  SAMPLE_BITS  captured word.
- data_valid  out  1  word available.
- data_ready  in  1  consumer accepts word.
- overrun  out  1  sticky: a word was overwritten before acceptance.
- clr_overrun  in  1  clears overrun.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, async) values:
  - state = IDLE, adc_rst = 1, adc_slp = 1.
  - data = 0, data_valid = 0, overrun = 0.
  - bit and period counters = 0.
  - The ADC is held reset while the controller is in reset.
- Out of reset in IDLE: adc_rst deasserts to 0 on the first clk edge; adc_slp stays 1.
- States:
  - IDLE: adc_slp = 1, adc_rst = 0.
    - If start = 1 at posedge s: enter RST, adc_rst <= 1.
  - RST: adc_rst = 1, adc_slp = 1 for exactly RST_CYCLES cycles.
    - On the last of these cycles: adc_rst <= 0, adc_slp <= 0, enter SHIFT, bit count = 0.
  - SHIFT: adc_slp = 0.
    - At every posedge, shreg <= {shreg[SAMPLE_BITS-2:0], adc_dout} and count increments.
    - Sampling uses the pre-edge dout, i.e. the ADC MSB before it rotates.
    - The ADC receives exactly SAMPLE_BITS edges, the first one posedge after adc_slp falls.
  - Word completion, at the SAMPLE_BITS-th SHIFT posedge:
    - data <= completed word and data_valid <= 1 on that same edge.
    - Latency from the start-sampling edge: RST_CYCLES + SAMPLE_BITS cycles.
    - If cont = 1 and period = 0: remain in SHIFT with adc_slp held 0 and count reset. This gives a gap-free stream.
    - If cont = 1 and period > 0: adc_slp <= 1, load counter = period, enter SLEEP.
    - If cont = 0: adc_slp <= 1, enter IDLE.
  - SLEEP: adc_slp = 1; counter decrements.
    - At the edge where counter == 1: adc_slp <= 0, enter SHIFT.
    - adc_slp is therefore high for exactly period cycles.
    - No ADC reset between words of one continuous run.
- Handshake:
  - data_valid stays high until a cycle with data_ready = 1; it clears on that edge.
  - data is stable while data_valid is high, except on overwrite (below).
  - Word completion in the same cycle as acceptance: data_valid stays 1 with the new word; no overrun.
  - Word completion while data_valid = 1 and data_ready = 0: data is overwritten and overrun <= 1.
  - overrun clears only via clr_overrun. If set and clear happen in the same cycle, set wins.
- Inputs ignored while not in IDLE: start.
- cont deasserted mid-word: the current word completes, then IDLE.
- period changes take effect only at the next SLEEP load.
- Mid-operation reset: all outputs return to reset values immediately; any partial word is discarded.

Test Plan:
- Single-shot: RST_CYCLES = 2, cont = 0, pulse start at cycle 0.
  - Required: adc_rst high for 2 cycles, then adc_slp low for exactly 8 cycles.
  - data = 0x55, data_valid rises at cycle 10.
  - Then IDLE with adc_slp = 1 and busy = 0.
- Continuous, cont = 1, period = 3, data_ready = 1:
  - Required: words of 0x55 repeat.
  - adc_slp high for exactly 3 cycles between 8-cycle low windows.
  - adc_rst pulses only once.
- Gap-free, cont = 1, period = 0:
  - Required: adc_slp stays 0 continuously.
  - data_valid completions every 8 cycles, each word 0x55.
- Backpressure, data_ready = 0, cont = 1, period = 2:
  - Required: the first word holds with data_valid = 1.
  - At the second completion, data updates and overrun = 1.
  - A clr_overrun pulse clears overrun.
  - A data_ready pulse clears data_valid.
- Abort and misuse:
  - Assert rst_n = 0 at SHIFT bit 4. Required: adc_rst = 1, adc_slp = 1, data_valid = 0 immediately; the next start yields a clean 0x55.
  - Assert start while busy. Required: no effect on the sequence.
